// File: rtl/rv_pkg.sv
// Shared RISC-V pipeline definitions: instruction width, NOP encoding, fetch FSM states.
package rv_pkg;

  localparam int          INSTR_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register holding valid/pc/instr with load, hold and flush.
// Load beats flush; flush clears only valid, so pc/instr keep their last value.
module if_id_reg
  import rv_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic                   flush_i,
  input  logic [ADDR_WIDTH-1:0]  pc_i,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  output logic                   valid_o,
  output logic [ADDR_WIDTH-1:0]  pc_o,
  output logic [INSTR_WIDTH-1:0] instr_o
);

  logic                   valid_q;
  logic [ADDR_WIDTH-1:0]  pc_q;
  logic [INSTR_WIDTH-1:0] instr_q;

  // Load a new entry, drop the current one, or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, addresses the combinational imem and fills
// the IF/ID register under decode back-pressure, execute redirects and halt.
module fetch_stage
  import rv_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int RESET_PC   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  input  logic                   halt_req,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic                   halted,
  output logic [31:0]            fetch_count
);

  localparam logic [ADDR_WIDTH-1:0] RESET_PC_A = ADDR_WIDTH'(RESET_PC) & ~ADDR_WIDTH'(3);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  load, flush, slot_free;
  logic [ADDR_WIDTH-1:0] redir_aligned;
  logic                  unused_redir_lsb;

  // Target low bits are dropped so the PC stays word aligned.
  assign redir_aligned    = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign unused_redir_lsb = ^redirect_pc[1:0];

  assign slot_free = !out_valid || out_ready;

  // State, PC and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC_A;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: redirect > halt > capture > stall. HALTED keeps IF/ID empty.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      RUN: begin
        if (redirect_valid) begin
          pc_d  = redir_aligned;
          flush = 1'b1;
        end else if (slot_free && halt_req) begin
          state_d = HALTED;
          flush   = 1'b1;
        end else if (slot_free) begin
          load  = 1'b1;
          pc_d  = pc_q + ADDR_WIDTH'(4);
          cnt_d = cnt_q + 32'd1;
        end
      end
      HALTED: begin
        flush = 1'b1;
        if (redirect_valid) begin
          pc_d    = redir_aligned;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  if_id_reg #(.ADDR_WIDTH(ADDR_WIDTH)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .flush_i (flush),
    .pc_i    (pc_q),
    .instr_i (imem_rdata),
    .valid_o (out_valid),
    .pc_o    (out_pc),
    .instr_o (out_instr)
  );

  assign imem_addr   = pc_q;
  assign halted      = (state_q == HALTED);
  assign fetch_count = cnt_q;

endmodule
